pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the pipelined MIPS datapath.
- Tracks the destination register, writeback intent and result latency of every in-flight instruction across NSTAGES post-decode stages (stage 1 = EX, stage NSTAGES = WB).
- Produces registered forwarding selects for the EX operands, a load-use stall, and flush control for branch/jump/JR redirects resolved in any stage.
- Replaces the fixed, hazard-free pipeline: same datapath, arbitrary depth, multi-cycle-latency producers.

---
 rtl/pipe_hazard_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight destinations across NSTAGES
// post-decode stages and produces forwarding selects, load-use stall and redirect flush.
module pipe_hazard_ctrl #(
    parameter int NSTAGES = 3,
    parameter int REGBITS = 5,
    parameter int LATW    = 2,
    parameter int SELW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [REGBITS-1:0] id_rs,
    input  logic [REGBITS-1:0] id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               id_regwrite,
    input  logic [REGBITS-1:0] id_wreg,
    input  logic [LATW-1:0]    id_lat,
    input  logic               redirect,
    input  logic [SELW-1:0]    redirect_stage,
    output logic               stall,
    output logic               flush_ifid,
    output logic [SELW-1:0]    fwd_a,
    output logic [SELW-1:0]    fwd_b,
    output logic [NSTAGES-1:0] stage_valid
);

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic [REGBITS-1:0] wreg;
        logic [LATW-1:0]    lat;
    } entry_t;

    // pipe_q[i] describes the instruction currently in stage i+1
    entry_t          pipe_q [NSTAGES];
    entry_t          id_entry;
    logic            a_req, b_req;
    logic            a_found, b_found;
    logic            a_wait, b_wait;
    logic [SELW-1:0] a_sel, b_sel;
    logic            load_id;

    function automatic logic hit(input entry_t e, input logic [REGBITS-1:0] r);
        return e.valid && e.regwrite && (e.wreg == r);
    endfunction

    assign id_entry = {1'b1, id_regwrite, id_wreg, id_lat};
    assign a_req    = id_valid && id_use_rs && (id_rs != '0);
    assign b_req    = id_valid && id_use_rt && (id_rt != '0);

    // Scan youngest-first; the first hit per operand decides, older hits are ignored.
    // A hit in the last stage leaves the select at 0 (register file is write-first).
    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_wait  = 1'b0;
        b_wait  = 1'b0;
        a_sel   = '0;
        b_sel   = '0;
        for (int unsigned i = 0; i < NSTAGES; i++) begin
            if (!a_found && a_req && hit(pipe_q[i], id_rs)) begin
                a_found = 1'b1;
                if (i + 1 < NSTAGES) begin
                    if (i + 1 >= 32'(pipe_q[i].lat)) a_sel = SELW'(i + 2);
                    else                             a_wait = 1'b1;
                end
            end
            if (!b_found && b_req && hit(pipe_q[i], id_rt)) begin
                b_found = 1'b1;
                if (i + 1 < NSTAGES) begin
                    if (i + 1 >= 32'(pipe_q[i].lat)) b_sel = SELW'(i + 2);
                    else                             b_wait = 1'b1;
                end
            end
        end
    end

    assign stall      = !reset && !redirect && (a_wait || b_wait);
    assign flush_ifid = !reset && redirect;
    assign load_id    = id_valid && !redirect && !(a_wait || b_wait);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NSTAGES; i++) pipe_q[i] <= '0;
            fwd_a <= '0;
            fwd_b <= '0;
        end else begin
            pipe_q[0] <= load_id ? id_entry : '0;
            // Entry moving out of stage i is squashed when it is younger than the redirector
            for (int unsigned i = 1; i < NSTAGES; i++) begin
                pipe_q[i] <= (redirect && (i < 32'(redirect_stage))) ? '0 : pipe_q[i-1];
            end
            fwd_a <= load_id ? a_sel : '0;
            fwd_b <= load_id ? b_sel : '0;
        end
    end

    for (genvar g = 0; g < NSTAGES; g++) begin : g_stage_valid
        assign stage_valid[g] = pipe_q[g].valid;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: 3- and 4-stage instances driven in parallel, checked
// against an instruction-list reference model, hand vectors and corner sequences.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_wreg;
    logic       id_use_rs, id_use_rt, id_regwrite;
    logic [1:0] id_lat;
    logic       redirect;
    logic [2:0] redirect_stage;

    logic       stall3, flush3, stall4, flush4;
    logic [2:0] fa3, fb3, fa4, fb4;
    logic [2:0] sv3;
    logic [3:0] sv4;

    pipe_hazard_ctrl #(.NSTAGES(3), .REGBITS(5), .LATW(2), .SELW(3)) dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwrite(id_regwrite),
        .id_wreg(id_wreg), .id_lat(id_lat), .redirect(redirect),
        .redirect_stage(redirect_stage), .stall(stall3), .flush_ifid(flush3),
        .fwd_a(fa3), .fwd_b(fb3), .stage_valid(sv3));

    pipe_hazard_ctrl #(.NSTAGES(4), .REGBITS(5), .LATW(2), .SELW(3)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_regwrite(id_regwrite),
        .id_wreg(id_wreg), .id_lat(id_lat), .redirect(redirect),
        .redirect_stage(redirect_stage), .stall(stall4), .flush_ifid(flush4),
        .fwd_a(fa4), .fwd_b(fb4), .stage_valid(sv4));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (redirect === 1'b1)
            assert (redirect_stage >= 3'd1 && redirect_stage <= 3'd3)
            else $error("illegal redirect_stage %0d", redirect_stage);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an unordered list of in-flight instructions, each tagged with its stage.
    typedef struct {
        bit live;
        int stage;
        bit rw;
        int wreg;
        int lat;
    } ins_t;

    ins_t lst [2][8];
    bit   mwait [2];
    bit   mst [2];
    bit   mfl [2];
    int   msa [2];
    int   msb [2];
    int   efa [2];
    int   efb [2];
    int   esv [2];
    int   obs_stall3, obs_flush3, obs_stall4;

    function automatic void lookup(input int m, input int n, input bit use_x, input int r,
                                   output bit w, output int sel);
        int best, blat;
        best = 0; blat = 0; w = 1'b0; sel = 0;
        if (!id_valid || !use_x || r == 0) return;
        for (int i = 0; i < 8; i++) begin
            if (lst[m][i].live && lst[m][i].rw && lst[m][i].wreg == r &&
                (best == 0 || lst[m][i].stage < best)) begin
                best = lst[m][i].stage;
                blat = lst[m][i].lat;
            end
        end
        if (best == 0 || best == n) return;
        if (best >= blat) sel = best + 1;
        else              w = 1'b1;
    endfunction

    function automatic void model_comb(input int m);
        bit wa, wb;
        int sa, sb;
        lookup(m, 3 + m, id_use_rs, int'(id_rs), wa, sa);
        lookup(m, 3 + m, id_use_rt, int'(id_rt), wb, sb);
        msa[m]   = sa;
        msb[m]   = sb;
        mwait[m] = wa || wb;
        mst[m]   = !reset && !redirect && mwait[m];
        mfl[m]   = !reset && redirect;
    endfunction

    function automatic void model_update(input int m);
        int  n;
        bit  load, placed;
        n = 3 + m;
        if (reset) begin
            for (int i = 0; i < 8; i++) lst[m][i].live = 1'b0;
            efa[m] = 0;
            efb[m] = 0;
        end else begin
            load = id_valid && !redirect && !mwait[m];
            for (int i = 0; i < 8; i++) begin
                if (lst[m][i].live) begin
                    if (redirect && lst[m][i].stage < int'(redirect_stage)) lst[m][i].live = 1'b0;
                    else begin
                        lst[m][i].stage++;
                        if (lst[m][i].stage > n) lst[m][i].live = 1'b0;
                    end
                end
            end
            placed = 1'b0;
            if (load) begin
                for (int i = 0; i < 8; i++) begin
                    if (!placed && !lst[m][i].live) begin
                        lst[m][i] = '{1'b1, 1, id_regwrite, int'(id_wreg), int'(id_lat)};
                        placed = 1'b1;
                    end
                end
            end
            efa[m] = load ? msa[m] : 0;
            efb[m] = load ? msb[m] : 0;
        end
        esv[m] = 0;
        for (int i = 0; i < 8; i++)
            if (lst[m][i].live) esv[m] |= (1 << (lst[m][i].stage - 1));
    endfunction

    // One clock: combinational outputs checked before the edge, registered ones after it.
    task automatic step();
        @(negedge clk);
        for (int m = 0; m < 2; m++) model_comb(m);
        check("stall_n3", int'(stall3), int'(mst[0]));
        check("flush_n3", int'(flush3), int'(mfl[0]));
        check("stall_n4", int'(stall4), int'(mst[1]));
        check("flush_n4", int'(flush4), int'(mfl[1]));
        obs_stall3 = int'(stall3);
        obs_flush3 = int'(flush3);
        obs_stall4 = int'(stall4);
        for (int m = 0; m < 2; m++) model_update(m);
        @(posedge clk);
        #1;
        check("fwd_a_n3", int'(fa3), efa[0]);
        check("fwd_b_n3", int'(fb3), efb[0]);
        check("valid_n3", int'(sv3), esv[0]);
        check("fwd_a_n4", int'(fa4), efa[1]);
        check("fwd_b_n4", int'(fb4), efb[1]);
        check("valid_n4", int'(sv4), esv[1]);
    endtask

    typedef struct {
        int v, rs, rt, ur, ut, rw, wr, lat, rd, rst;
        int e_st, e_fl, e_fa, e_fb, e_sv;
    } vec_t;

    vec_t tab [22];

    task automatic drive(input int v, input int rs, input int rt, input int ur, input int ut,
                         input int rw, input int wr, input int lat, input int rd, input int rst);
        id_valid       = 1'(v);
        id_rs          = 5'(rs);
        id_rt          = 5'(rt);
        id_use_rs      = 1'(ur);
        id_use_rt      = 1'(ut);
        id_regwrite    = 1'(rw);
        id_wreg        = 5'(wr);
        id_lat         = 2'(lat);
        redirect       = 1'(rd);
        redirect_stage = 3'(rst);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v  rs rt ur ut rw wr lat rd rst  st fl fa fb sv
        tab[0]  = '{1, 0, 0, 0, 0, 1, 2, 1, 0, 0,  0, 0, 0, 0, 1};
        tab[1]  = '{1, 2, 3, 1, 1, 1, 8, 1, 0, 0,  0, 0, 2, 0, 3};
        tab[2]  = '{1, 29, 0, 1, 0, 1, 4, 2, 0, 0, 0, 0, 0, 0, 7};
        tab[3]  = '{1, 4, 4, 1, 1, 1, 5, 1, 0, 0,  1, 0, 0, 0, 6};
        tab[4]  = '{1, 4, 4, 1, 1, 1, 5, 1, 0, 0,  0, 0, 3, 3, 5};
        tab[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 2};
        tab[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 4};
        tab[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0};
        tab[8]  = '{1, 0, 0, 0, 0, 1, 4, 2, 0, 0,  0, 0, 0, 0, 1};
        tab[9]  = '{1, 9, 0, 1, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 3};
        tab[10] = '{1, 4, 0, 1, 0, 0, 0, 1, 0, 0,  0, 0, 3, 0, 7};
        tab[11] = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 7};
        tab[12] = '{1, 0, 10, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7};
        tab[13] = '{1, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, 0, 0, 0, 7};
        tab[14] = '{1, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, 0, 0, 0, 7};
        tab[15] = '{1, 7, 7, 1, 0, 0, 0, 1, 0, 0,  0, 0, 2, 0, 7};
        tab[16] = '{1, 7, 0, 1, 0, 1, 9, 1, 1, 3,  0, 1, 0, 0, 0};
        tab[17] = '{1, 0, 0, 0, 0, 1, 3, 1, 0, 0,  0, 0, 0, 0, 1};
        tab[18] = '{1, 0, 0, 0, 0, 1, 6, 1, 0, 0,  0, 0, 0, 0, 3};
        tab[19] = '{1, 6, 0, 1, 0, 1, 11, 1, 1, 1, 0, 1, 0, 0, 6};
        tab[20] = '{1, 0, 0, 0, 0, 1, 4, 2, 0, 0,  0, 0, 0, 0, 5};
        tab[21] = '{1, 4, 4, 1, 1, 1, 5, 1, 1, 2,  0, 1, 0, 0, 0};

        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 8; i++) lst[m][i] = '{1'b0, 0, 1'b0, 0, 0};

        // Reset with live-looking inputs: outputs must stay quiet
        reset = 1'b1;
        drive(1, 4, 4, 1, 1, 1, 4, 1, 1, 2);
        #1;
        step();
        check("reset_stall", obs_stall3, 0);
        check("reset_flush", obs_flush3, 0);
        check("reset_valid", int'(sv3), 0);
        check("reset_fwd_a", int'(fa3), 0);
        check("reset_fwd_b", int'(fb3), 0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(tab[i].v, tab[i].rs, tab[i].rt, tab[i].ur, tab[i].ut, tab[i].rw,
                  tab[i].wr, tab[i].lat, tab[i].rd, tab[i].rst);
            step();
            check($sformatf("tab%0d_stall", i), obs_stall3, tab[i].e_st);
            check($sformatf("tab%0d_flush", i), obs_flush3, tab[i].e_fl);
            check($sformatf("tab%0d_fwd_a", i), int'(fa3), tab[i].e_fa);
            check($sformatf("tab%0d_fwd_b", i), int'(fb3), tab[i].e_fb);
            check($sformatf("tab%0d_valid", i), int'(sv3), tab[i].e_sv);
        end

        // Latency-3 producer: two stalls on the 4-stage pipe, write-first select on the 3-stage one
        reset = 1'b1; idle(); step(); reset = 1'b0;
        drive(1, 0, 0, 0, 0, 1, 4, 3, 0, 0); step();
        drive(1, 4, 4, 1, 1, 1, 5, 1, 0, 0); step();
        check("lat3_stall_c1", obs_stall4, 1);
        step();
        check("lat3_stall_c2", obs_stall4, 1);
        step();
        check("lat3_stall_c3", obs_stall4, 0);
        check("lat3_fwd_a_n4", int'(fa4), 4);
        check("lat3_fwd_b_n4", int'(fb4), 4);
        check("lat3_fwd_a_n3", int'(fa3), 0);
        idle(); repeat (4) step();

        // Reset while a stall is pending and a redirect is requested
        drive(1, 0, 0, 0, 0, 1, 4, 3, 0, 0); step();
        drive(1, 4, 0, 1, 0, 1, 5, 1, 0, 0); step();
        check("rst_mid_stall_before", obs_stall3, 1);
        reset = 1'b1;
        drive(1, 4, 0, 1, 0, 1, 5, 1, 1, 2); step();
        check("rst_mid_stall", obs_stall3, 0);
        check("rst_mid_flush", obs_flush3, 0);
        check("rst_mid_valid_n3", int'(sv3), 0);
        check("rst_mid_valid_n4", int'(sv4), 0);
        check("rst_mid_fwd_a", int'(fa3), 0);
        reset = 1'b0;
        idle(); step();
        check("rst_mid_after_stall", obs_stall3, 0);
        check("rst_mid_after_valid", int'(sv3), 0);

        // Random traffic on a small register set against the model
        for (int c = 0; c < 600; c++) begin
            reset          = ($urandom_range(0, 63) == 0);
            id_valid       = ($urandom_range(0, 3) != 0);
            id_rs          = 5'($urandom_range(0, 7));
            id_rt          = 5'($urandom_range(0, 7));
            id_use_rs      = 1'($urandom_range(0, 1));
            id_use_rt      = 1'($urandom_range(0, 1));
            id_regwrite    = 1'($urandom_range(0, 1));
            id_wreg        = 5'($urandom_range(0, 7));
            id_lat         = 2'($urandom_range(1, 3));
            redirect       = ($urandom_range(0, 7) == 0);
            redirect_stage = 3'($urandom_range(1, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
